regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_pkg.sv | 8 +
 rtl/regfile_scoreboard.sv | 54 +++++
 rtl/regfile_sb.sv | 95 +++++++++
 tb/tb_regfile_sb.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and index type for the scoreboarded register file.
package regfile_pkg;
  localparam int XLEN_DEF = 64;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = $clog2(NREG_DEF);

  typedef logic [AW_DEF-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: issue check, per-port busy lookup, and flush > set > clear priority.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int NRP  = 2,
  parameter int NWP  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NRP*AW-1:0] rd_idx,
  output logic [NRP-1:0]    rd_busy,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  output logic              iss_ready,
  input  logic [NWP-1:0]    wb_en,
  input  logic [NWP*AW-1:0] wb_idx,
  input  logic              flush
);

  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;

  // Registered state only, so a same-cycle write-back cannot unblock issue.
  assign iss_ready = !busy_reg[iss_rd];

  genvar gi;
  generate
    for (gi = 0; gi < NRP; gi++) begin : g_rd
      assign rd_busy[gi] = busy_reg[rd_idx[gi*AW +: AW]];
    end
  endgenerate

  always_comb begin
    busy_next = busy_reg;
    if (flush) begin
      busy_next = '0;
    end else begin
      for (int w = 0; w < NWP; w++) begin
        if (wb_en[w]) busy_next[wb_idx[w*AW +: AW]] = 1'b0;
      end
      // Allocation is applied last so it wins over a same-index write-back.
      if (iss_valid && iss_ready && (iss_rd != '0)) busy_next[iss_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) busy_reg <= '0;
    else       busy_reg <= busy_next;
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with hardwired x0 and an issue scoreboard.
// Define REGFILE_SB_BYPASS_EN to forward same-cycle write-back data to the read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRP  = 2,
  parameter int NWP  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NRP*AW-1:0]   rd_idx,
  output logic [NRP*XLEN-1:0] rd_data,
  output logic [NRP-1:0]      rd_busy,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic                iss_ready,
  input  logic [NWP-1:0]      wb_en,
  input  logic [NWP*AW-1:0]   wb_idx,
  input  logic [NWP*XLEN-1:0] wb_data,
  input  logic                flush
);

  logic [NREG*XLEN-1:0] regs_flat;
  logic [NRP-1:0]       sb_busy;

  regfile_scoreboard #(
    .NREG (NREG),
    .NRP  (NRP),
    .NWP  (NWP)
  ) u_sb (
    .clk       (clk),
    .rstn      (rstn),
    .rd_idx    (rd_idx),
    .rd_busy   (sb_busy),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .wb_en     (wb_en),
    .wb_idx    (wb_idx),
    .flush     (flush)
  );

  assign regs_flat[XLEN-1:0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_reg
      logic [XLEN-1:0] q_reg;
      logic [XLEN-1:0] q_next;

      // Ascending port scan: the highest-numbered matching port wins.
      always_comb begin
        q_next = q_reg;
        for (int w = 0; w < NWP; w++) begin
          if (wb_en[w] && (wb_idx[w*AW +: AW] == AW'(gi))) q_next = wb_data[w*XLEN +: XLEN];
        end
      end

      always_ff @(posedge clk) begin
        if (!rstn) q_reg <= '0;
        else       q_reg <= q_next;
      end

      assign regs_flat[gi*XLEN +: XLEN] = q_reg;
    end

    for (gi = 0; gi < NRP; gi++) begin : g_rd
      logic [AW-1:0]   idx;
      logic [XLEN-1:0] data;
      logic            busy;

      assign idx = rd_idx[gi*AW +: AW];

      always_comb begin
        data = regs_flat[idx*XLEN +: XLEN];
        busy = sb_busy[gi];
`ifdef REGFILE_SB_BYPASS_EN
        for (int w = 0; w < NWP; w++) begin
          if (wb_en[w] && (wb_idx[w*AW +: AW] == idx) && (idx != '0)) begin
            data = wb_data[w*XLEN +: XLEN];
            busy = 1'b0;
          end
        end
`endif
      end

      assign rd_data[gi*XLEN +: XLEN] = data;
      assign rd_busy[gi]              = busy;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Directed test of regfile_sb: reset, hazard, port conflict, x0, flush, set-over-clear, bypass.
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NRP  = 2;
  localparam int NWP  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rstn;
  logic [NRP*AW-1:0]   rd_idx;
  logic [NRP*XLEN-1:0] rd_data;
  logic [NRP-1:0]      rd_busy;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                iss_ready;
  logic [NWP-1:0]      wb_en;
  logic [NWP*AW-1:0]   wb_idx;
  logic [NWP*XLEN-1:0] wb_data;
  logic                flush;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .wb_en     (wb_en),
    .wb_idx    (wb_idx),
    .wb_data   (wb_data),
    .flush     (flush)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end else begin
      $display("ok   %s value=%0h", tag, obs);
    end
  endtask

  task automatic idle();
    iss_valid = 1'b0;
    iss_rd    = '0;
    wb_en     = '0;
    wb_idx    = '0;
    wb_data   = '0;
    flush     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input int port, input reg_idx_t idx, input logic [63:0] data);
    wb_en[port]                 = 1'b1;
    wb_idx[port*AW +: AW]       = idx;
    wb_data[port*XLEN +: XLEN]  = data;
  endtask

  task automatic rd(input reg_idx_t idx0, input reg_idx_t idx1);
    rd_idx = {idx1, idx0};
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    rstn   = 1'b0;
    rd_idx = '0;
    idle();
    // Reset must override activity on the write and issue paths.
    wb(0, 5'd1, 64'hAB);
    iss_valid = 1'b1;
    iss_rd    = 5'd2;
    repeat (2) tick();
    rstn = 1'b1;
    idle();
    #1;

    for (int i = 0; i < NREG; i++) begin
      rd(reg_idx_t'(i), reg_idx_t'(NREG - 1 - i));
      check($sformatf("rst_data_x%0d", i), rd_data[63:0], 64'h0);
      check($sformatf("rst_busy_x%0d", i), {63'h0, rd_busy[0]}, 64'h0);
      check($sformatf("rst_p1_x%0d", NREG - 1 - i), rd_data[127:64], 64'h0);
    end
    iss_rd = 5'd2;
    #1;
    check("rst_iss_ready", {63'h0, iss_ready}, 64'h1);

    // Hazard on x5
    iss_valid = 1'b1;
    iss_rd    = 5'd5;
    tick();
    rd(5'd5, 5'd0);
    check("haz_busy_x5", {63'h0, rd_busy[0]}, 64'h1);
    check("haz_iss_ready_x5", {63'h0, iss_ready}, 64'h0);
    wb(0, 5'd5, 64'hDEAD);
    #1;
    check("haz_ready_wb_same_cycle", {63'h0, iss_ready}, 64'h0);
`ifdef REGFILE_SB_BYPASS_EN
    check("haz_wb_busy_same_cycle", {63'h0, rd_busy[0]}, 64'h0);
`else
    check("haz_wb_busy_same_cycle", {63'h0, rd_busy[0]}, 64'h1);
`endif
    tick();
    idle();
    rd(5'd5, 5'd5);
    check("haz_data_x5", rd_data[63:0], 64'hDEAD);
    check("haz_data_x5_p1", rd_data[127:64], 64'hDEAD);
    check("haz_busy_clr_x5", {63'h0, rd_busy[0]}, 64'h0);

    // Same-cycle write conflict: port 1 wins
    wb(0, 5'd7, 64'h1);
    wb(1, 5'd7, 64'h2);
    tick();
    idle();
    rd(5'd7, 5'd0);
    check("conflict_x7", rd_data[63:0], 64'h2);

    // x0 is hardwired
    wb(1, 5'd0, 64'hFF);
    iss_valid = 1'b1;
    iss_rd    = 5'd0;
    #1;
    check("x0_iss_ready_same", {63'h0, iss_ready}, 64'h1);
    tick();
    idle();
    rd(5'd0, 5'd0);
    check("x0_data", rd_data[63:0], 64'h0);
    check("x0_busy", {63'h0, rd_busy[0]}, 64'h0);
    check("x0_iss_ready", {63'h0, iss_ready}, 64'h1);

    // Flush drops x3/x4, suppresses issue of x9, keeps write of x10
    iss_valid = 1'b1;
    iss_rd    = 5'd3;
    tick();
    iss_rd    = 5'd4;
    tick();
    idle();
    rd(5'd3, 5'd4);
    check("fl_pre_busy_x3", {63'h0, rd_busy[0]}, 64'h1);
    check("fl_pre_busy_x4", {63'h0, rd_busy[1]}, 64'h1);
    flush     = 1'b1;
    iss_valid = 1'b1;
    iss_rd    = 5'd9;
    wb(0, 5'd10, 64'h77);
    tick();
    idle();
    rd(5'd3, 5'd4);
    check("fl_busy_x3", {63'h0, rd_busy[0]}, 64'h0);
    check("fl_busy_x4", {63'h0, rd_busy[1]}, 64'h0);
    rd(5'd9, 5'd10);
    check("fl_busy_x9", {63'h0, rd_busy[0]}, 64'h0);
    check("fl_wb_x10", rd_data[127:64], 64'h77);
    iss_rd = 5'd9;
    #1;
    check("fl_iss_ready_x9", {63'h0, iss_ready}, 64'h1);

    // Allocation wins over same-cycle write-back clear
    iss_valid = 1'b1;
    iss_rd    = 5'd6;
    wb(1, 5'd6, 64'h66);
    tick();
    idle();
    rd(5'd6, 5'd0);
    check("setclr_busy_x6", {63'h0, rd_busy[0]}, 64'h1);
    check("setclr_data_x6", rd_data[63:0], 64'h66);

    // Bypass behaviour on x8
    wb(0, 5'd8, 64'h11);
    tick();
    idle();
    rd(5'd8, 5'd0);
    check("byp_old_x8", rd_data[63:0], 64'h11);
    wb(0, 5'd8, 64'h55);
    #1;
`ifdef REGFILE_SB_BYPASS_EN
    check("byp_same_cycle_x8", rd_data[63:0], 64'h55);
`else
    check("byp_same_cycle_x8", rd_data[63:0], 64'h11);
`endif
    check("byp_busy_x8", {63'h0, rd_busy[0]}, 64'h0);
    tick();
    idle();
    rd(5'd8, 5'd0);
    check("byp_next_x8", rd_data[63:0], 64'h55);

    // Reset in mid-operation clears data and busy
    rstn = 1'b0;
    wb(0, 5'd5, 64'h99);
    tick();
    rstn = 1'b1;
    idle();
    rd(5'd5, 5'd6);
    check("rst2_data_x5", rd_data[63:0], 64'h0);
    check("rst2_busy_x6", {63'h0, rd_busy[1]}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
